forward_decode_unit: RTL and testbench
======================================

FORWARD_DECODE_UNIT -- requirements
Module: forward_decode_unit

Interface
REQ-001 Parameter DEPTH, default 2: number of retired-instruction history slots checked for forwarding, legal range 1..4.
REQ-002 Parameter IW, default 16: instruction width; the field positions below are fixed for IW=16.
REQ-003 Parameter RAW, default 3: register-address width.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, asynchronous and active-high.
REQ-006 Port in_valid  input  1: the instruction in cmd is valid in this cycle.
REQ-007 Port cmd  input  IW: instruction currently in decode.
REQ-008 Port in_ready  output  1: decode accepts cmd this cycle (not stalled).
REQ-009 Port flush  input  1: pipeline redirect; discards the history.
REQ-010 Port fwd_a  output  DEPTH: one-hot forwarding select for operand A (bit k = history slot k); all-zero selects the register file.
REQ-011 Port fwd_b  output  DEPTH: one-hot forwarding select for operand B, same encoding as fwd_a.
REQ-012 Port load_stall  output  1: load-use hazard detected this cycle.
REQ-013 Port flag_write  output  1: the accepted instruction updates the flags.

Function
REQ-014 Producer classes: ALU ([15:14]=11, func [7:4]<=1100, func!=0101, func!=0111) with dest [10:8]; LI/ADDI ([15:11]=10000/10001) with dest [10:8]; LD ([15:14]=00) with dest [13:11].
REQ-015 Operand A consumers: ALU with func 0000..0110 or 1101, and ST ([15:14]=01); source A = [13:11].
REQ-016 Operand B consumers: ALU with func 0000..0101 or 1000..1011, ST, LD and ADDI; source B = [10:8].
REQ-017 History is a shift register of DEPTH entries {valid, dest, is_load}; slot 0 holds the most recently accepted instruction.
REQ-018 Acceptance: an instruction is accepted when in_valid=1 and in_ready=1; on acceptance the history shifts and slot 0 receives the instruction's producer info (valid=0 for non-producers).
REQ-019 fwd_a and fwd_b are combinational from cmd and the history; bit k is set for the lowest-index valid slot whose dest equals the source; at most one bit is set.
REQ-020 fwd_a and fwd_b are all-zero when in_valid=0 or when the operand is not consumed.
REQ-021 load_stall=1 when slot 0 is a valid LD and its dest matches a consumed source of cmd while in_valid=1.
REQ-022 in_ready = !load_stall.
REQ-023 While load_stall=1, the history shifts and slot 0 receives a bubble (valid=0), so the hazard clears after exactly one cycle and the load then forwards from slot 1.
REQ-024 When in_valid=0, the history still shifts and inserts a bubble, keeping slot age equal to the cycle distance.
REQ-025 flush=1 clears every valid bit on the next edge; flush has priority over acceptance and over bubble insertion.
REQ-026 flag_write=1 for accepted ALU instructions with func <=1011 and !=0111, and for ADDI; otherwise 0, including when in_ready=0.
REQ-027 With DEPTH=1, only slot 0 is checked; a producer 2 cycles old reads the register file.

Reset
REQ-028 While rst=1, all history valid bits and is_load bits are 0 and all dest fields are 0.
REQ-029 With history clear, fwd_a=0, fwd_b=0, load_stall=0, in_ready=1 and flag_write=0 (with in_valid=0).
REQ-030 Reset asserted mid-stall drops the stall immediately and asynchronously.

Structure
REQ-031 Shared package holds: the instruction-class opcode constants, the ALU func codes (ADD..IDT, CMP=0101, MOV=0110, IN=1100, OUT=1101), and the history-entry struct type.
REQ-032 One sub-module, fwd_match, compares one source against one history slot and returns a hit; it is instantiated DEPTH times per operand, followed by a priority encoder in the parent.

Verification
REQ-033 ADD r3 (dest 3), then an ALU instruction reading A=r3 -> fwd_a=01, fwd_b=00.
REQ-034 ADD r3, then NOP, then an ALU instruction reading B=r3 with DEPTH=2 -> fwd_b=10; the same sequence with DEPTH=1 -> fwd_b=0.
REQ-035 LD r5, then ST reading r5 -> load_stall=1 and in_ready=0 for exactly one cycle; the following cycle fwd_a=10 and in_ready=1.
REQ-036 ADD r2 in slot 1 and ADDI r2 in slot 0, then a consumer of B=r2 -> fwd_b=01 (nearest producer wins).
REQ-037 ADD r4 accepted, then flush=1, then a consumer of r4 -> fwd_a=0 and fwd_b=0.
REQ-038 rst asserted during a load_stall -> load_stall drops the same cycle; after release, history is empty and CMP is accepted with flag_write=1.

Source files
------------

// File: rtl/forward_decode_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : forward_decode_unit_pkg
//  Description : Shared definitions for the forward/decode unit: instruction
//                class opcodes, ALU function codes and the history entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package forward_decode_unit_pkg;

    // Register-address width the instruction field layout is built around.
    localparam int REG_AW = 3;

    // Instruction classes, cmd[15:14].
    localparam logic [1:0] CLS_LD  = 2'b00;
    localparam logic [1:0] CLS_ST  = 2'b01;
    localparam logic [1:0] CLS_ALU = 2'b11;

    // Immediate forms, cmd[15:11].
    localparam logic [4:0] OP_LI   = 5'b10000;
    localparam logic [4:0] OP_ADDI = 5'b10001;

    // ALU function codes, cmd[7:4].
    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0001;
    localparam logic [3:0] FN_AND = 4'b0010;
    localparam logic [3:0] FN_OR  = 4'b0011;
    localparam logic [3:0] FN_XOR = 4'b0100;
    localparam logic [3:0] FN_CMP = 4'b0101;
    localparam logic [3:0] FN_MOV = 4'b0110;
    localparam logic [3:0] FN_NOP = 4'b0111;
    localparam logic [3:0] FN_SHL = 4'b1000;
    localparam logic [3:0] FN_SHR = 4'b1001;
    localparam logic [3:0] FN_SAR = 4'b1010;
    localparam logic [3:0] FN_IDT = 4'b1011;
    localparam logic [3:0] FN_IN  = 4'b1100;
    localparam logic [3:0] FN_OUT = 4'b1101;

    // One retired-instruction history slot.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } hist_entry_t;

endpackage
`default_nettype wire

// File: rtl/forward_decode_unit_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_match
//  Description : Compares one source register against one history slot.
//  Ports       : src   - source register address of the decoding instruction
//                entry - history slot contents
//                hit   - slot holds a valid producer of src
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_match
    import forward_decode_unit_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  hist_entry_t       entry,
    output logic              hit
);

    assign hit = entry.valid && (entry.dest == src);

    // Load tagging only matters for the stall check in the parent.
    logic unused_is_load;
    assign unused_is_load = entry.is_load;

endmodule
`default_nettype wire

// File: rtl/forward_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forward_decode_unit
//  Description : Decode-stage operand forwarding selects, load-use stall and
//                flag-write decode, driven by a DEPTH-deep history of
//                recently accepted producers.
//  Ports       : clk, rst            - clock, async active-high reset
//                in_valid, cmd       - instruction in decode
//                in_ready            - decode not stalled
//                flush               - pipeline redirect, empties history
//                fwd_a, fwd_b        - one-hot forwarding selects (0 = regfile)
//                load_stall          - load-use hazard this cycle
//                flag_write          - accepted instruction writes flags
//  Revision    : 1.0 - initial release
// ============================================================================
module forward_decode_unit
    import forward_decode_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IW    = 16,
    parameter int RAW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IW-1:0]    cmd,
    output logic             in_ready,
    input  logic             flush,
    output logic [DEPTH-1:0] fwd_a,
    output logic [DEPTH-1:0] fwd_b,
    output logic             load_stall,
    output logic             flag_write
);

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [1:0]     cls;
    logic [4:0]     op5;
    logic [3:0]     func;
    logic [RAW-1:0] src_a;
    logic [RAW-1:0] src_b;
    logic           is_alu, is_st, is_ld, is_li, is_addi;
    logic           alu_prod, producer, use_a, use_b, writes_flags;
    logic [RAW-1:0] prod_dest;

    assign cls   = cmd[15:14];
    assign op5   = cmd[15:11];
    assign func  = cmd[7:4];
    assign src_a = cmd[13:11];
    assign src_b = cmd[10:8];

    assign is_alu  = (cls == CLS_ALU);
    assign is_st   = (cls == CLS_ST);
    assign is_ld   = (cls == CLS_LD);
    assign is_li   = (op5 == OP_LI);
    assign is_addi = (op5 == OP_ADDI);

    // CMP only sets flags and NOP does nothing; OUT and above write no register.
    assign alu_prod  = is_alu && (func <= FN_IN) && (func != FN_CMP) && (func != FN_NOP);
    assign producer  = alu_prod || is_li || is_addi || is_ld;
    // Loads put their destination in the A field; everything else uses B.
    assign prod_dest = is_ld ? cmd[13:11] : cmd[10:8];

    assign use_a = (is_alu && ((func <= FN_MOV) || (func == FN_OUT))) || is_st;
    assign use_b = (is_alu && ((func <= FN_CMP) || ((func >= FN_SHL) && (func <= FN_IDT))))
                   || is_st || is_ld || is_addi;

    assign writes_flags = (is_alu && (func <= FN_IDT) && (func != FN_NOP)) || is_addi;

    logic unused_low_bits;
    assign unused_low_bits = ^cmd[3:0];

    // ------------------------------------------------------------------
    // History shift register; slot 0 is the youngest entry.
    // ------------------------------------------------------------------
    hist_entry_t hist [DEPTH];
    hist_entry_t new_entry;
    logic        accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        new_entry = '0;
        if (accept && producer) begin
            new_entry.valid   = 1'b1;
            new_entry.dest    = prod_dest;
            new_entry.is_load = is_ld;
        end
    end

    // Shifting every cycle (bubble when nothing is accepted) keeps slot index
    // equal to cycle age, which is what makes a stalled load forward from
    // slot 1 on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
        end else begin
            hist[0] <= new_entry;
            for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Per-slot matching and nearest-producer priority
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] hit_a, hit_b;
    logic [DEPTH-1:0] sel_a, sel_b;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        fwd_match u_match_a (
            .src   (src_a),
            .entry (hist[k]),
            .hit   (hit_a[k])
        );
        fwd_match u_match_b (
            .src   (src_b),
            .entry (hist[k]),
            .hit   (hit_b[k])
        );
    end

    // Scan oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit_a[k]) begin
                sel_a    = '0;
                sel_a[k] = 1'b1;
            end
            if (hit_b[k]) begin
                sel_b    = '0;
                sel_b[k] = 1'b1;
            end
        end
    end

    assign fwd_a = (in_valid && use_a) ? sel_a : '0;
    assign fwd_b = (in_valid && use_b) ? sel_b : '0;

    // ------------------------------------------------------------------
    // Load-use hazard and flag write
    // ------------------------------------------------------------------
    assign load_stall = in_valid && hist[0].valid && hist[0].is_load &&
                        ((use_a && (hist[0].dest == src_a)) ||
                         (use_b && (hist[0].dest == src_b)));
    assign in_ready   = !load_stall;
    assign flag_write = accept && writes_flags;

endmodule
`default_nettype wire

// File: tb/tb_forward_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_forward_decode_unit
//  Description : Self-checking bench for forward_decode_unit (DEPTH 2 and 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_decode_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] cmd = 16'h0000;

    logic       in_ready2, load_stall2, flag_write2;
    logic [1:0] fwd_a2, fwd_b2;
    logic       in_ready1, load_stall1, flag_write1;
    logic [0:0] fwd_a1, fwd_b1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    forward_decode_unit #(.DEPTH(2), .IW(16), .RAW(3)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .cmd(cmd), .in_ready(in_ready2),
        .flush(flush), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .load_stall(load_stall2),
        .flag_write(flag_write2)
    );

    forward_decode_unit #(.DEPTH(1), .IW(16), .RAW(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .cmd(cmd), .in_ready(in_ready1),
        .flush(flush), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .load_stall(load_stall1),
        .flag_write(flag_write1)
    );

    // ---------------- reference model ----------------
    typedef struct {bit v; bit [2:0] d; bit ld;} ment_t;
    typedef struct {bit prod; bit [2:0] pd; bit ld; bit ua; bit ub; bit fw;
                    bit [2:0] sa; bit [2:0] sb;} dec_t;

    // Age-ordered list of the last four cycles' retirements (index = age).
    ment_t mh [4];

    function automatic dec_t decode(input logic [15:0] c);
        dec_t r;
        int   f;
        r = '{default: 0};
        r.sa = c[13:11];
        r.sb = c[10:8];
        f = int'(c[7:4]);
        case (c[15:14])
            2'b00: begin r.prod = 1; r.pd = c[13:11]; r.ld = 1; r.ub = 1; end
            2'b01: begin r.ua = 1; r.ub = 1; end
            2'b10: begin
                if (c[13:11] == 3'b000) begin r.prod = 1; r.pd = c[10:8]; end
                if (c[13:11] == 3'b001) begin r.prod = 1; r.pd = c[10:8]; r.ub = 1; r.fw = 1; end
            end
            default: begin
                r.prod = (f <= 12) && (f != 5) && (f != 7);
                r.pd   = c[10:8];
                r.ua   = (f <= 6) || (f == 13);
                r.ub   = (f <= 5) || (f >= 8 && f <= 11);
                r.fw   = (f <= 11) && (f != 7);
            end
        endcase
        return r;
    endfunction

    function automatic bit exp_stall(input dec_t dd);
        return (in_valid === 1'b1) && mh[0].v && mh[0].ld &&
               ((dd.ua && mh[0].d == dd.sa) || (dd.ub && mh[0].d == dd.sb));
    endfunction

    function automatic logic [3:0] exp_sel(input bit use_op, input bit [2:0] src, input int d);
        logic [3:0] one;
        one = 4'b0001;
        if (in_valid !== 1'b1 || !use_op) return 4'b0000;
        for (int k = 0; k < d; k++)
            if (mh[k].v && mh[k].d == src) return one << k;
        return 4'b0000;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) mh[k] = '{0, 3'd0, 0};
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        dec_t       dd;
        bit         st, fw;
        logic [3:0] ea2, eb2, ea1, eb1;
        dd  = decode(cmd);
        st  = exp_stall(dd);
        fw  = (in_valid === 1'b1) && !st && dd.fw;
        ea2 = exp_sel(dd.ua, dd.sa, 2);
        eb2 = exp_sel(dd.ub, dd.sb, 2);
        ea1 = exp_sel(dd.ua, dd.sa, 1);
        eb1 = exp_sel(dd.ub, dd.sb, 1);
        chk({tag, ".stall2"}, {3'b0, load_stall2}, {3'b0, st});
        chk({tag, ".ready2"}, {3'b0, in_ready2},   {3'b0, !st});
        chk({tag, ".flagw2"}, {3'b0, flag_write2}, {3'b0, fw});
        chk({tag, ".fwda2"},  {2'b0, fwd_a2},      ea2);
        chk({tag, ".fwdb2"},  {2'b0, fwd_b2},      eb2);
        chk({tag, ".stall1"}, {3'b0, load_stall1}, {3'b0, st});
        chk({tag, ".ready1"}, {3'b0, in_ready1},   {3'b0, !st});
        chk({tag, ".flagw1"}, {3'b0, flag_write1}, {3'b0, fw});
        chk({tag, ".fwda1"},  {3'b0, fwd_a1},      ea1);
        chk({tag, ".fwdb1"},  {3'b0, fwd_b1},      eb1);
    endtask

    task automatic apply(input logic v, input logic [15:0] c, input logic f, input string tag);
        in_valid = v;
        cmd      = c;
        flush    = f;
        #1;
        check_all(tag);
    endtask

    // Advance one clock: the model retires what the edge sees, then we move
    // to the falling edge where new inputs are driven.
    task automatic tick();
        dec_t dd;
        bit   st;
        @(posedge clk);
        dd = decode(cmd);
        st = exp_stall(dd);
        if (rst || flush) begin
            model_clear();
        end else begin
            for (int k = 3; k >= 1; k--) mh[k] = mh[k-1];
            if (in_valid && !st && dd.prod) mh[0] = '{1, dd.pd, dd.ld};
            else                            mh[0] = '{0, 3'd0, 0};
        end
        @(negedge clk);
    endtask

    // ---------------- instruction builders ----------------
    function automatic logic [15:0] alu(input logic [3:0] f, input logic [2:0] a, input logic [2:0] b);
        return {2'b11, a, b, f, 4'b0000};
    endfunction
    function automatic logic [15:0] ld(input logic [2:0] d, input logic [2:0] b);
        return {2'b00, d, b, 8'h00};
    endfunction
    function automatic logic [15:0] st(input logic [2:0] a, input logic [2:0] b);
        return {2'b01, a, b, 8'h00};
    endfunction
    function automatic logic [15:0] addi(input logic [2:0] d);
        return {5'b10001, d, 8'h05};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        model_clear();

        // Reset state
        #1;
        apply(1'b0, 16'hFFFF, 1'b0, "reset");
        chk("reset.ready2", {3'b0, in_ready2}, 4'h1);
        chk("reset.fwd2", {fwd_a2, fwd_b2}, 4'h0);
        tick();
        tick();
        rst = 1'b0;

        // Forward operand A from slot 0
        apply(1'b1, alu(4'b0000, 3'd0, 3'd3), 1'b0, "add_r3");
        chk("add_r3.flagw", {3'b0, flag_write2}, 4'h1);
        tick();
        apply(1'b1, alu(4'b0110, 3'd3, 3'd1), 1'b0, "mov_from_r3");
        chk("mov_from_r3.fwda", {2'b0, fwd_a2}, 4'h1);
        chk("mov_from_r3.fwdb", {2'b0, fwd_b2}, 4'h0);
        tick();

        // Two-cycle-old producer: slot 1 for DEPTH=2, register file for DEPTH=1
        apply(1'b1, alu(4'b0000, 3'd0, 3'd3), 1'b0, "add_r3b");
        tick();
        apply(1'b1, alu(4'b0111, 3'd0, 3'd0), 1'b0, "nop");
        chk("nop.flagw", {3'b0, flag_write2}, 4'h0);
        tick();
        apply(1'b1, alu(4'b1000, 3'd0, 3'd3), 1'b0, "shl_r3");
        chk("shl_r3.fwdb2", {2'b0, fwd_b2}, 4'h2);
        chk("shl_r3.fwdb1", {3'b0, fwd_b1}, 4'h0);
        tick();

        // Load-use: one stall cycle, then forward from slot 1
        apply(1'b1, ld(3'd5, 3'd0), 1'b0, "ld_r5");
        tick();
        apply(1'b1, st(3'd5, 3'd1), 1'b0, "st_stall");
        chk("st_stall.stall", {3'b0, load_stall2}, 4'h1);
        chk("st_stall.ready", {3'b0, in_ready2}, 4'h0);
        tick();
        apply(1'b1, st(3'd5, 3'd1), 1'b0, "st_go");
        chk("st_go.fwda2", {2'b0, fwd_a2}, 4'h2);
        chk("st_go.ready", {3'b0, in_ready2}, 4'h1);
        chk("st_go.fwda1", {3'b0, fwd_a1}, 4'h0);
        tick();

        // Nearest producer wins
        apply(1'b1, alu(4'b0000, 3'd0, 3'd2), 1'b0, "add_r2");
        tick();
        apply(1'b1, addi(3'd2), 1'b0, "addi_r2");
        chk("addi_r2.flagw", {3'b0, flag_write2}, 4'h1);
        tick();
        apply(1'b1, alu(4'b1001, 3'd0, 3'd2), 1'b0, "shr_r2");
        chk("shr_r2.fwdb2", {2'b0, fwd_b2}, 4'h1);
        tick();

        // Flush discards history
        apply(1'b1, alu(4'b0000, 3'd0, 3'd4), 1'b0, "add_r4");
        tick();
        apply(1'b0, 16'h0000, 1'b1, "flush");
        tick();
        apply(1'b1, alu(4'b0000, 3'd4, 3'd4), 1'b0, "use_r4");
        chk("use_r4.fwd2", {fwd_a2, fwd_b2}, 4'h0);
        tick();

        // Flush wins over acceptance
        apply(1'b1, alu(4'b0000, 3'd0, 3'd6), 1'b1, "add_r6_flush");
        tick();
        apply(1'b1, alu(4'b0000, 3'd6, 3'd6), 1'b0, "use_r6");
        chk("use_r6.fwd2", {fwd_a2, fwd_b2}, 4'h0);
        tick();

        // Asynchronous reset during a stall
        apply(1'b1, ld(3'd5, 3'd0), 1'b0, "ld_r5b");
        tick();
        apply(1'b1, st(3'd5, 3'd1), 1'b0, "st_stall2");
        chk("st_stall2.stall", {3'b0, load_stall2}, 4'h1);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_mid.stall", {3'b0, load_stall2}, 4'h0);
        chk("rst_mid.ready", {3'b0, in_ready2}, 4'h1);
        tick();
        rst = 1'b0;
        apply(1'b1, alu(4'b0101, 3'd1, 3'd2), 1'b0, "cmp_after_rst");
        chk("cmp_after_rst.flagw", {3'b0, flag_write2}, 4'h1);
        chk("cmp_after_rst.ready", {3'b0, in_ready2}, 4'h1);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] c;
            c = 16'($urandom);
            // Bias register fields toward a small set to raise hit rates.
            if ($urandom_range(0, 1) == 1) c[13:12] = 2'b00;
            if ($urandom_range(0, 1) == 1) c[10:9]  = 2'b00;
            apply(($urandom_range(0, 3) != 0), c, ($urandom_range(0, 15) == 0), "rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
